// File: rtl/dram_fifo_pkg.sv
// Shared constants for the DVI pipeline blocks and the FIFO's per-cycle
// operation encoding.
package dram_fifo_pkg;

  localparam int unsigned DVI_DATA_WIDTH = 20;
  localparam int unsigned DVI_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/dram_nxm.sv
// DEPTH x DATA_WIDTH distributed RAM: port A synchronous write with
// asynchronous read, port B asynchronous read only.
module dram_nxm #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr_a] <= din_a;
  end

  assign dout_a = mem[addr_a];
  assign dout_b = mem[addr_b];

endmodule

// File: rtl/dram_fifo.sv
// First-word-fall-through FIFO over a distributed RAM, with registered
// occupancy flags and one-cycle overflow/underflow pulses.
module dram_fifo
  import dram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DVI_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DVI_ADDR_WIDTH,
  parameter int unsigned AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_LEVEL = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned        DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  fifo_op_e              op;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
  always_comb begin
    rd_ok      = RD_EN && !EMPTY;
    wr_ok      = WR_EN && (!FULL || rd_ok);
    op         = fifo_op(wr_ok, rd_ok);
    count_next = COUNT;
    case (op)
      OP_WRITE: count_next = COUNT + CNT_ONE;
      OP_READ:  count_next = COUNT - CNT_ONE;
      default:  count_next = COUNT;
    endcase
  end

  assign ram_we = wr_ok && !RST;

  dram_nxm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (CLK),
    .we     (ram_we),
    .addr_a (wr_ptr),
    .din_a  (DIN),
    .dout_a (wr_word),
    .addr_b (rd_ptr),
    .dout_b (rd_word)
  );

  // Pointers coincide only when empty or full; both ports then address the head word.
  assign DOUT = (wr_ptr == rd_ptr) ? wr_word : rd_word;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      COUNT        <= count_next;
      FULL         <= (count_next == DEPTH_CNT);
      EMPTY        <= (count_next == '0);
      ALMOST_FULL  <= (count_next >= AFULL_CNT);
      ALMOST_EMPTY <= (count_next <= AEMPTY_CNT);
      OVERFLOW     <= WR_EN && !wr_ok;
      UNDERFLOW    <= RD_EN && EMPTY;
    end
  end

endmodule

// File: doc/dram_fifo.md
DRAM_FIFO -- requirements
Module: dram_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 20, bits per word.
REQ-002 Parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16).
REQ-003 Parameter AFULL_LEVEL, default DEPTH-2, COUNT at or above which ALMOST_FULL asserts.
REQ-004 Parameter AEMPTY_LEVEL, default 2, COUNT at or below which ALMOST_EMPTY asserts.
REQ-005 CLK  input  1  sole clock, all state updates on rising edge.
REQ-006 RST  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-007 DIN  input  DATA_WIDTH  write data.
REQ-008 WR_EN  input  1  write request.
REQ-009 RD_EN  input  1  read request (pop head word).
REQ-010 DOUT  output  DATA_WIDTH  head word, first-word-fall-through.
REQ-011 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  output  1 each  occupancy flags.
REQ-012 COUNT  output  ADDR_WIDTH+1  words stored, 0..DEPTH.
REQ-013 OVERFLOW, UNDERFLOW  output  1 each  one-cycle error pulses.

Function
REQ-014 Storage SHALL be DEPTH x DATA_WIDTH distributed RAM: synchronous write at wr_ptr, asynchronous read at rd_ptr.
REQ-015 Write accepted when WR_EN and (not FULL or RD_EN accepted same cycle); stores DIN at wr_ptr, wr_ptr increments.
REQ-016 Read accepted when RD_EN and not EMPTY; rd_ptr increments.
REQ-017 DOUT SHALL equal mem[rd_ptr] combinationally; valid whenever EMPTY=0; value don't-care when EMPTY=1.
REQ-018 Write-to-DOUT latency: word written into empty FIFO at edge N visible on DOUT and EMPTY=0 after edge N.
REQ-019 Pointers ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally.
REQ-020 COUNT: +1 write only, -1 read only, unchanged on both or neither; registered.
REQ-021 FULL = (COUNT==DEPTH); EMPTY = (COUNT==0); ALMOST_FULL = (COUNT>=AFULL_LEVEL); ALMOST_EMPTY = (COUNT<=AEMPTY_LEVEL); all registered, updated same edge as COUNT.
REQ-022 Full and WR_EN and RD_EN: both performed, COUNT stays DEPTH, no OVERFLOW.
REQ-023 Empty and WR_EN and RD_EN: write only, read ignored, UNDERFLOW pulses.
REQ-024 WR_EN while FULL without RD_EN: write dropped, memory/pointers unchanged, OVERFLOW high for next cycle only.
REQ-025 RD_EN while EMPTY: ignored, UNDERFLOW high for next cycle only.

Reset
REQ-026 RST asserted SHALL immediately clear wr_ptr, rd_ptr, COUNT to 0; EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0 (given AFULL_LEVEL>0), OVERFLOW=0, UNDERFLOW=0.
REQ-027 RAM contents not cleared; reset mid-operation discards all stored words.
REQ-028 WR_EN/RD_EN ignored while RST high; normal operation from first edge after release.

Structure
REQ-029 Shared package/include holds default DATA_WIDTH (20) and ADDR_WIDTH (4) constants used by DVI pipeline blocks.
REQ-030 One sub-module dram_nxm: parametrised DEPTH x DATA_WIDTH dual-port RAM, one write/read port, one read-only port; dram_fifo instantiates it and owns pointers, count, flags.

Verification
REQ-031 Reset, write 0x00001..0x00010 (16 words) -> FULL=1, COUNT=16, ALMOST_FULL from COUNT=14; DOUT=0x00001.
REQ-032 From full, read 16 -> DOUT sequence 0x00001..0x00010, EMPTY=1 after last read, ALMOST_EMPTY from COUNT=2.
REQ-033 Full, WR_EN=1 only -> OVERFLOW single-cycle pulse, COUNT 16, contents intact; empty, RD_EN=1 only -> UNDERFLOW pulse.
REQ-034 Full, WR_EN=RD_EN=1 with DIN=0xABCDE -> COUNT 16, FULL stays 1, 0xABCDE read out after 15 further words; empty with both -> COUNT 1, UNDERFLOW pulse, DOUT=written word.
REQ-035 Continuous write+read at COUNT=8 for 40 cycles -> pointers wrap, data in order, COUNT fixed 8.
REQ-036 Assert RST asynchronously mid-burst at COUNT=5 -> flags/COUNT reset before next edge, EMPTY=1; next write reappears at DOUT.
